// File: rtl/sequence_checker.sv
// sequence_checker: serial pattern lock detector.
// In SEARCH it looks for one full period of PATTERN in the valid bit stream.
// In LOCKED it checks each valid bit against the expected bit for the current
// phase, and reports per-bit errors and error-free periods. Lock is dropped
// after LOSS_THR consecutive mismatches.
module sequence_checker #(
    parameter logic [5:0] PATTERN  = 6'b001011,
    parameter int         LOSS_THR = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_in,
    input  logic       in_valid,
    input  logic       err_clr,
    output logic       locked,
    output logic       frame_ok,
    output logic       bit_err,
    output logic [7:0] err_cnt
);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t     state;
    logic [5:0] hist;
    logic [2:0] fill;
    logic [2:0] phase;
    logic [2:0] miss_cnt;
    logic       per_err;

    logic [5:0] next_hist;
    logic       exp_bit;
    logic       mism;
    logic       loss;
    logic       found;

    // Per-bit decisions derived from the current state and incoming bit.
    always_comb begin
        next_hist = {hist[4:0], data_in};
        found     = (fill >= 3'd5) && (next_hist == PATTERN);
        exp_bit   = PATTERN[3'd5 - phase];
        mism      = data_in ^ exp_bit;
        loss      = mism && (({1'b0, miss_cnt} + 4'd1) == 4'(LOSS_THR));
    end

    // State machine, alignment tracking and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SEARCH;
            locked   <= 1'b0;
            frame_ok <= 1'b0;
            bit_err  <= 1'b0;
            err_cnt  <= 8'd0;
            hist     <= 6'd0;
            fill     <= 3'd0;
            phase    <= 3'd0;
            miss_cnt <= 3'd0;
            per_err  <= 1'b0;
        end else begin
            frame_ok <= 1'b0;
            bit_err  <= 1'b0;

            // A clear wins over a coincident increment.
            if (err_clr)
                err_cnt <= 8'd0;
            else if (state == LOCKED && in_valid && mism && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;

            if (in_valid) begin
                case (state)
                    SEARCH: begin
                        hist <= next_hist;
                        if (found) begin
                            state    <= LOCKED;
                            locked   <= 1'b1;
                            frame_ok <= 1'b1;
                            phase    <= 3'd0;
                            per_err  <= 1'b0;
                            miss_cnt <= 3'd0;
                            fill     <= 3'd6;
                        end else if (fill != 3'd6) begin
                            fill <= fill + 3'd1;
                        end
                    end
                    LOCKED: begin
                        bit_err <= mism;
                        if (loss) begin
                            // Drop all alignment so re-lock needs fresh bits.
                            state    <= SEARCH;
                            locked   <= 1'b0;
                            hist     <= 6'd0;
                            fill     <= 3'd0;
                            phase    <= 3'd0;
                            per_err  <= 1'b0;
                            miss_cnt <= 3'd0;
                        end else begin
                            miss_cnt <= mism ? miss_cnt + 3'd1 : 3'd0;
                            if (phase == 3'd5) begin
                                frame_ok <= ~(per_err | mism);
                                per_err  <= 1'b0;
                                phase    <= 3'd0;
                            end else begin
                                per_err  <= per_err | mism;
                                phase    <= phase + 3'd1;
                            end
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sequence_checker.sv
// Testbench for sequence_checker: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based behavioural model.
module tb_sequence_checker;

    localparam logic [5:0] PAT = 6'b001011;
    localparam int         THR = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       data_in = 1'b0;
    logic       in_valid = 1'b0;
    logic       err_clr = 1'b0;
    logic       locked;
    logic       frame_ok;
    logic       bit_err;
    logic [7:0] err_cnt;

    sequence_checker #(.PATTERN(PAT), .LOSS_THR(THR)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .in_valid (in_valid),
        .err_clr  (err_clr),
        .locked   (locked),
        .frame_ok (frame_ok),
        .bit_err  (bit_err),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model state.
    logic [5:0] pat_v = PAT;
    int  hist_q[$];
    bit  m_locked = 0;
    int  m_pos = 0;
    int  m_run = 0;
    int  m_per_errs = 0;
    int  m_cnt = 0;
    bit  m_frame = 0;
    bit  m_bit = 0;

    // Position in the transmitted ideal stream (counts valid bits only).
    int  sidx = 0;

    function automatic bit pat_bit(input int i);
        return pat_v[5 - (i % 6)];
    endfunction

    task automatic model_update(input bit r, input bit v, input bit d, input bit c);
        bit match;
        m_frame = 0;
        m_bit   = 0;
        if (r) begin
            hist_q.delete();
            m_locked = 0; m_pos = 0; m_run = 0; m_per_errs = 0; m_cnt = 0;
            return;
        end
        if (v) begin
            if (!m_locked) begin
                hist_q.push_back(int'(d));
                if (hist_q.size() > 6) void'(hist_q.pop_front());
                match = (hist_q.size() == 6);
                for (int i = 0; i < hist_q.size(); i++)
                    if (hist_q[i] != int'(pat_v[5 - i])) match = 0;
                if (match) begin
                    m_locked = 1; m_pos = 0; m_run = 0; m_per_errs = 0; m_frame = 1;
                end
            end else begin
                if (d != pat_v[5 - m_pos]) begin
                    m_bit = 1;
                    if (m_cnt < 255) m_cnt++;
                    m_run++;
                    m_per_errs++;
                end else begin
                    m_run = 0;
                end
                if (m_run == THR) begin
                    m_locked = 0; hist_q.delete();
                    m_run = 0; m_per_errs = 0; m_pos = 0;
                end else begin
                    if (m_pos == 5) begin
                        m_frame = (m_per_errs == 0);
                        m_per_errs = 0;
                    end
                    m_pos = (m_pos + 1) % 6;
                end
            end
        end
        if (c) m_cnt = 0;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance model, compare all outputs after the edge.
    task automatic tick(input bit r, input bit v, input bit d, input bit c);
        rst = r; in_valid = v; data_in = d; err_clr = c;
        model_update(r, v, d, c);
        @(posedge clk);
        @(negedge clk);
        check("locked",   int'(locked),   int'(m_locked));
        check("frame_ok", int'(frame_ok), int'(m_frame));
        check("bit_err",  int'(bit_err),  int'(m_bit));
        check("err_cnt",  int'(err_cnt),  m_cnt);
    endtask

    task automatic send(input bit inv, input bit c);
        bit d;
        d = pat_bit(sidx) ^ inv;
        sidx++;
        tick(0, 1, d, c);
    endtask

    // Send clean aligned bits until the model reports lock (bounded).
    task automatic relock(input string name);
        int n = 0;
        while (!m_locked && n < 20) begin
            send(0, 0);
            n++;
        end
        checks++;
        if (!m_locked) begin
            errors++;
            $display("FAIL %s: no lock within %0d bits", name, n);
        end
    endtask

    initial begin
        @(negedge clk);
        tick(1, 0, 0, 0);
        tick(1, 1, 1, 1);
        check("reset_locked", int'(locked), 0);
        check("reset_cnt", int'(err_cnt), 0);

        // Clean stream: lock on the sixth bit, then periodic frame_ok.
        for (int i = 0; i < 6; i++) send(0, 0);
        check("first_lock", int'(locked), 1);
        check("first_frame", int'(frame_ok), 1);
        for (int i = 0; i < 24; i++) send(0, 0);
        check("clean_cnt", int'(err_cnt), 0);

        // Single inverted bit at phase 2.
        send(0, 0); send(0, 0); send(1, 0);
        check("single_biterr", int'(bit_err), 1);
        check("single_cnt", int'(err_cnt), 1);
        for (int i = 0; i < 3; i++) send(0, 0);
        check("no_frame_bad_period", int'(frame_ok), 0);
        for (int i = 0; i < 6; i++) send(0, 0);
        check("frame_next_period", int'(frame_ok), 1);
        check("still_locked", int'(locked), 1);

        // Three consecutive bad bits drop lock.
        send(0, 0);
        send(1, 0); send(1, 0);
        check("two_bad_locked", int'(locked), 1);
        send(1, 0);
        check("loss_unlocked", int'(locked), 0);
        check("loss_biterr", int'(bit_err), 1);
        check("loss_cnt", int'(err_cnt), 4);
        relock("relock_after_loss");

        // Valid gaps: only valid bits advance phase.
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 2) == 0) send(0, 0);
            else tick(0, 0, 1'($urandom), 0);
        end

        // Repeated loss/re-lock to saturate the counter.
        for (int k = 0; k < 90; k++) begin
            relock("sat_relock");
            send(1, 0); send(1, 0); send(1, 0);
        end
        check("saturated", int'(err_cnt), 255);
        relock("pre_clr_relock");
        send(1, 1);
        check("clr_with_err_bit", int'(bit_err), 1);
        check("clr_with_err_cnt", int'(err_cnt), 0);
        send(0, 0);

        // Error then reset mid-period while locked.
        send(1, 0);
        relock("pre_rst_relock");
        send(0, 0); send(0, 0);
        tick(1, 1, 1'($urandom), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_cnt", int'(err_cnt), 0);
        relock("relock_after_rst");

        // Randomized traffic with occasional errors, clears and resets.
        for (int i = 0; i < 800; i++) begin
            int p;
            p = $urandom_range(0, 99);
            if (p == 0) tick(1, 1'($urandom), 1'($urandom), 1'($urandom));
            else if (p < 30) tick(0, 0, 1'($urandom), p < 3);
            else send($urandom_range(0, 9) == 0, p == 99);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sequence_checker.md
SEQUENCE_CHECKER -- requirements
Module: sequence_checker

Parameters
REQ-001 SHALL have parameter PATTERN, default 6'b001011, the expected 6-bit period; PATTERN[5] is received first.
REQ-002 SHALL have parameter LOSS_THR, default 3, the number of consecutive mismatched bits that drops lock (legal range 1..7).

Interface
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 data_in  input  1  serial bit under check.
REQ-006 in_valid  input  1  data_in is sampled only when high.
REQ-007 err_clr  input  1  synchronous clear of err_cnt.
REQ-008 locked  output  1  high while in LOCKED state.
REQ-009 frame_ok  output  1  one-cycle pulse per error-free full period.
REQ-010 bit_err  output  1  one-cycle pulse per mismatched bit while locked.
REQ-011 err_cnt  output  8  saturating count of bit_err events.

Function
REQ-012 All outputs SHALL be registered; each response appears the cycle after the sampling edge of the valid bit that causes it.
REQ-013 With in_valid low, SHALL hold state, shift register, phase and counters; frame_ok and bit_err SHALL be 0.
REQ-014 State machine SHALL have two states, SEARCH and LOCKED; locked = (state == LOCKED).
REQ-015 SEARCH: each valid bit SHALL shift into a 6-bit history register (newest in LSB); a fill counter SHALL saturate at 6.
REQ-016 SEARCH -> LOCKED SHALL occur when, including the current bit, fill = 6 and the history equals PATTERN; phase SHALL then be set to 0 and frame_ok SHALL pulse.
REQ-017 SEARCH SHALL never assert bit_err or change err_cnt.
REQ-018 LOCKED: expected bit SHALL be PATTERN[5-phase]; phase SHALL advance 0..5 and wrap 5->0 on each valid bit.
REQ-019 LOCKED mismatch SHALL pulse bit_err, increment err_cnt (saturating at 255) and increment the consecutive-mismatch counter.
REQ-020 LOCKED match SHALL clear the consecutive-mismatch counter.
REQ-021 A per-period error flag SHALL be set by any mismatch; on the bit with phase = 5, frame_ok SHALL pulse if the flag is clear (including the current bit), and the flag SHALL clear.
REQ-022 When the consecutive-mismatch counter reaches LOSS_THR, SHALL return to SEARCH on that same edge, clearing fill, history, phase, period flag and mismatch counter; bit_err still pulses for that bit.
REQ-023 After loss of lock, re-lock SHALL require 6 fresh valid bits matching PATTERN (no reuse of pre-loss history).
REQ-024 err_clr SHALL set err_cnt to 0; when err_clr and an increment coincide, the result SHALL be 0.
REQ-025 err_cnt SHALL persist across lock loss and re-lock; only rst or err_clr clears it.

Reset
REQ-026 rst high at a rising edge SHALL force state = SEARCH, locked = 0, frame_ok = 0, bit_err = 0, err_cnt = 0, history = 0, fill = 0, phase = 0, mismatch counter = 0, period flag = 0.
REQ-027 rst SHALL take priority over in_valid and err_clr; asserting rst mid-period SHALL discard all alignment.

Verification
REQ-028 After reset, feed continuous valid stream 0,0,1,0,1,1 repeating -> locked rises 1 cycle after 6th bit with frame_ok pulse; frame_ok pulses every 6 valid bits thereafter; bit_err never asserted; err_cnt = 0.
REQ-029 While locked, invert one bit at phase 2 -> single bit_err pulse, err_cnt = 1, no frame_ok for that period, locked stays 1, next period gives frame_ok.
REQ-030 While locked, invert 3 consecutive bits (LOSS_THR = 3) -> 3 bit_err pulses, err_cnt = 3, locked falls 1 cycle after third bad bit; re-lock only after 6 clean aligned bits.
REQ-031 Locked stream with in_valid toggled 1,0,0,1 in a random pattern -> phase and frame_ok spacing count only valid bits; no pulses on invalid cycles.
REQ-032 Force 260 mismatches with periodic re-lock -> err_cnt saturates at 255; assert err_clr together with a bit_err -> err_cnt = 0 next cycle.
REQ-033 Assert rst for one cycle mid-period while locked -> next cycle locked = 0, err_cnt = 0, all pulses 0; stream resumes and re-locks after 6 aligned bits.
